imem_loader: RTL and testbench

Boot-time instruction loader for the `microprocessor` core. It receives a framed byte stream from a host over a valid/ready handshake and assembles 32-bit instruction words. It writes those words into the core's instruction memory through a write port, and holds the core in reset until a complete, checksum-verified image has been written. It is the writer side of the instruction memory; the core's fetch path is the reader.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Bus bundles for the boot loader: host byte stream in, instruction-memory write port out.
interface byte_stream_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

interface imem_wr_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction loader: parses a count/payload/checksum byte frame, writes 32-bit
// words into instruction memory, and keeps the core in reset until the image verifies.
module imem_loader #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                start,
    byte_stream_if.slave        rx,
    imem_wr_if.master           mem,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [ADDR_WIDTH:0] words_loaded
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COUNT   = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [8:0]          CAPACITY = 9'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]          state_q, state_d;
    logic [7:0]          xor_q, xor_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         asm_q, asm_d;
    logic [ADDR_WIDTH:0] n_q, n_d;
    logic [ADDR_WIDTH:0] words_q, words_d;
    logic                xfer;

    assign rx.rx_ready = (state_q == S_COUNT) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign xfer        = rx.rx_valid && rx.rx_ready;

    always_comb begin
        state_d = state_q;
        xor_d   = xor_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        n_d     = n_q;
        words_d = words_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_COUNT;
                    xor_d   = 8'd0;
                    idx_d   = 2'd0;
                    words_d = '0;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    // A legal count never exceeds 2^ADDR_WIDTH, so ADDR_WIDTH+1 bits hold it.
                    n_d   = rx.rx_data[ADDR_WIDTH:0];
                    xor_d = rx.rx_data;
                    if (rx.rx_data == 8'd0 || {1'b0, rx.rx_data} > CAPACITY) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    asm_d = {asm_q[23:0], rx.rx_data};
                    xor_d = xor_q ^ rx.rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + ONE;
                state_d = (words_d == n_q) ? S_CHECK : S_PAYLOAD;
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = (rx.rx_data == xor_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            xor_q   <= 8'd0;
            idx_q   <= 2'd0;
            asm_q   <= 32'd0;
            n_q     <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            xor_q   <= xor_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            n_q     <= n_d;
            words_q <= words_d;
        end
    end

    // Status outputs decode straight from the registered state, so they change on the deciding edge.
    assign mem.mem_we    = (state_q == S_WRITE);
    assign mem.mem_addr  = words_q[ADDR_WIDTH-1:0];
    assign mem.mem_wdata = asm_q;
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERROR);
    assign cpu_hold      = (state_q != S_DONE);
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized and directed frames checked against a frame-level model
// through an expected-write queue drained by an independent monitor.
module tb_imem_loader;
    localparam int AW = 5;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    byte_stream_if              rx ();
    imem_wr_if #(.ADDR_WIDTH(AW)) mem ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .rx           (rx),
        .mem          (mem),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame[$];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the next expected write, with the byte port closed.
    always @(negedge clk) begin
        if (mem.mem_we === 1'b1) begin
            wr_t e;
            check("rx_ready_during_write", 64'(rx.rx_ready), 64'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, expected no write",
                         mem.mem_addr, mem.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 64'(mem.mem_addr), 64'(e.addr));
                check("write_data", 64'(mem.mem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_rx_ready", 64'(rx.rx_ready), 64'd1);
        check("start_cpu_hold", 64'(cpu_hold), 64'd1);
        check("start_done",     64'(done), 64'd0);
        check("start_err",      64'(err), 64'd0);
        check("start_words",    64'(words_loaded), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            rx.rx_valid = 1'b0;
        end
        @(negedge clk);
        rx.rx_valid = 1'b1;
        rx.rx_data  = b;
        guard = 0;
        while (rx.rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: byte %0h not accepted, expected acceptance", b);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n));
        cs = 8'(n);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            frame.push_back(b);
            cs ^= b;
        end
        frame.push_back(corrupt ? (cs ^ 8'h5A) : cs);
    endtask

    // Model: interpret the whole frame from the byte-level rules, then drive it and check the end state.
    task automatic run_frame(input int gap_max);
        int         n;
        int         nbytes;
        logic [7:0] cs;
        bit         exp_done;
        int         exp_words;
        wr_t        w;
        n = int'(frame[0]);
        if (n == 0 || n > CAP) begin
            exp_done  = 1'b0;
            exp_words = 0;
            nbytes    = 1;
        end else begin
            cs = 8'd0;
            for (int i = 0; i <= 4 * n; i++) cs ^= frame[i];
            for (int k = 0; k < n; k++) begin
                w.addr = AW'(k);
                w.data = {frame[1 + 4 * k], frame[2 + 4 * k], frame[3 + 4 * k], frame[4 + 4 * k]};
                exp_q.push_back(w);
            end
            exp_done  = (frame[4 * n + 1] == cs);
            exp_words = n;
            nbytes    = 4 * n + 2;
        end
        for (int i = 0; i < nbytes; i++) begin
            send_byte(frame[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        @(negedge clk);
        rx.rx_valid = 1'b0;
        check("end_done",     64'(done), 64'(exp_done));
        check("end_err",      64'(err), 64'(!exp_done));
        check("end_cpu_hold", 64'(cpu_hold), 64'(!exp_done));
        check("end_words",    64'(words_loaded), 64'(exp_words));
        check("end_rx_ready", 64'(rx.rx_ready), 64'd0);
        check("end_mem_we",   64'(mem.mem_we), 64'd0);
        check("end_pending_writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_hold"},  64'(cpu_hold), 64'd1);
        check({tag, "_done"},      64'(done), 64'd0);
        check({tag, "_err"},       64'(err), 64'd0);
        check({tag, "_rx_ready"},  64'(rx.rx_ready), 64'd0);
        check({tag, "_mem_we"},    64'(mem.mem_we), 64'd0);
        check({tag, "_words"},     64'(words_loaded), 64'd0);
        check({tag, "_mem_addr"},  64'(mem.mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem.mem_wdata), 64'd0);
    endtask

    task automatic load_good_frame(input logic [7:0] last);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, last};
    endtask

    initial begin
        wr_t w0;
        sys_rst     = 1'b1;
        start       = 1'b0;
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        sys_rst = 1'b0;

        // Directed frames: good, bad checksum, both illegal counts, good with gaps.
        load_good_frame(8'h21);
        pulse_start();
        run_frame(0);
        load_good_frame(8'h20);
        pulse_start();
        run_frame(0);
        frame = '{8'h00};
        pulse_start();
        run_frame(0);
        frame = '{8'h21};
        pulse_start();
        run_frame(0);
        load_good_frame(8'h21);
        pulse_start();
        run_frame(3);

        // Abort after the sixth byte: first word already written, partial second word dropped.
        pulse_start();
        w0.addr = '0;
        w0.data = 32'h00000001;
        exp_q.push_back(w0);
        load_good_frame(8'h21);
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
        @(negedge clk);
        rx.rx_valid = 1'b0;
        sys_rst     = 1'b1;
        @(negedge clk);
        check_reset_values("abort");
        check("abort_pending_writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        sys_rst = 1'b0;
        pulse_start();
        run_frame(0);

        // Full capacity and randomized frames.
        build_frame(CAP, 1'b0);
        pulse_start();
        run_frame(1);
        for (int t = 0; t < 10; t++) begin
            build_frame(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0));
            pulse_start();
            run_frame(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
